// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx between NREQ byte streams
// One byte per grant; an optional source-ID header byte precedes the first byte after a source change.
module uart_tx_arbiter #(
  parameter  int          NREQ     = 4,
  parameter  int          DBIT     = 8,
  parameter  int          HDR_EN   = 1,
  parameter  int unsigned HDR_BASE = 32'hA0,
  localparam int          IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DBIT-1:0] din,
  output logic [NREQ-1:0]      ack,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 tx_start,
  output logic [DBIT-1:0]      tx_din,
  input  logic                 tx_done_tick
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HDR  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  state_t            r_state;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_last_id;
  logic              r_hdr_valid;
  logic [IDW-1:0]    r_grant;
  logic              r_busy;
  logic [NREQ-1:0]   r_ack;
  logic              r_tx_start;
  logic [DBIT-1:0]   r_tx_din;

  state_t            w_state_nxt;
  logic [IDW-1:0]    w_ptr_nxt;
  logic [IDW-1:0]    w_last_id_nxt;
  logic              w_hdr_valid_nxt;
  logic [IDW-1:0]    w_grant_nxt;
  logic              w_busy_nxt;
  logic [NREQ-1:0]   w_ack_nxt;
  logic              w_tx_start_nxt;
  logic [DBIT-1:0]   w_tx_din_nxt;

  logic              w_found;
  logic [IDW-1:0]    w_sel;
  logic [DBIT-1:0]   w_sel_data;
  logic [DBIT-1:0]   w_grant_data;
  logic [DBIT-1:0]   w_hdr;
  logic              w_need_hdr;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Scan starts at r_ptr so the most recently served source is considered last.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req[wrap_add(r_ptr, k)]) begin
        w_found = 1'b1;
        w_sel   = wrap_add(r_ptr, k);
      end
    end
  end

  assign w_sel_data   = din[w_sel*DBIT +: DBIT];
  assign w_grant_data = din[r_grant*DBIT +: DBIT];
  assign w_hdr        = DBIT'(HDR_BASE + 32'(w_sel));
  assign w_need_hdr   = (HDR_EN != 0) && (!r_hdr_valid || (w_sel != r_last_id));

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_last_id_nxt   = r_last_id;
    w_hdr_valid_nxt = r_hdr_valid;
    w_grant_nxt     = r_grant;
    w_busy_nxt      = r_busy;
    w_ack_nxt       = '0;
    w_tx_start_nxt  = 1'b0;
    w_tx_din_nxt    = r_tx_din;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_nxt    = w_sel;
          w_busy_nxt     = 1'b1;
          w_tx_start_nxt = 1'b1;
          if (w_need_hdr) begin
            w_tx_din_nxt = w_hdr;
            w_state_nxt  = WAIT_HDR;
          end else begin
            w_tx_din_nxt = w_sel_data;
            w_ack_nxt    = NREQ'(1) << w_sel;
            w_state_nxt  = WAIT_DATA;
          end
        end
      end
      WAIT_HDR: begin
        if (tx_done_tick) begin
          w_last_id_nxt   = r_grant;
          w_hdr_valid_nxt = 1'b1;
          // A requester that dropped req during its header forfeits the data slot.
          if (req[r_grant]) begin
            w_tx_start_nxt = 1'b1;
            w_tx_din_nxt   = w_grant_data;
            w_ack_nxt      = NREQ'(1) << r_grant;
            w_state_nxt    = WAIT_DATA;
          end else begin
            w_busy_nxt  = 1'b0;
            w_ptr_nxt   = wrap_add(r_grant, 1);
            w_state_nxt = IDLE;
          end
        end
      end
      WAIT_DATA: begin
        if (tx_done_tick) begin
          w_busy_nxt    = 1'b0;
          w_ptr_nxt     = wrap_add(r_grant, 1);
          w_last_id_nxt = r_grant;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_last_id   <= '0;
      r_hdr_valid <= 1'b0;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_ack       <= '0;
      r_tx_start  <= 1'b0;
      r_tx_din    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_last_id   <= w_last_id_nxt;
      r_hdr_valid <= w_hdr_valid_nxt;
      r_grant     <= w_grant_nxt;
      r_busy      <= w_busy_nxt;
      r_ack       <= w_ack_nxt;
      r_tx_start  <= w_tx_start_nxt;
      r_tx_din    <= w_tx_din_nxt;
    end
  end

  assign ack      = r_ack;
  assign busy     = r_busy;
  assign grant_id = r_grant;
  assign tx_start = r_tx_start;
  assign tx_din   = r_tx_din;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a behavioural uart_tx stand-in
module tb_uart_tx_arbiter;

  localparam int FRAME = 5;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] ack;
    logic [1:0] gid;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] din = '0;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  grant_id;
  logic        tx_start;
  logic [7:0]  tx_din;
  logic        model_done = 1'b0;
  logic        force_done = 1'b0;
  logic        done_in;

  logic [3:0]  req_nh = '0;
  logic [31:0] din_nh = '0;
  logic [3:0]  ack_nh;
  logic        busy_nh;
  logic [1:0]  grant_id_nh;
  logic        tx_start_nh;
  logic [7:0]  tx_din_nh;
  logic        done_nh = 1'b0;

  logic        m_busy = 1'b0, m_busy_nh = 1'b0;
  int          m_cnt = 0, m_cnt_nh = 0;
  int          ack_cnt[4] = '{0, 0, 0, 0};
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];

  assign done_in = model_done | force_done;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(4), .DBIT(8), .HDR_EN(1), .HDR_BASE(32'hA0)) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req), .din(din), .ack(ack), .busy(busy),
    .grant_id(grant_id), .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(done_in)
  );

  uart_tx_arbiter #(.NREQ(4), .DBIT(8), .HDR_EN(0), .HDR_BASE(32'hA0)) u_dut_nh (
    .clk(clk), .reset_n(reset_n), .req(req_nh), .din(din_nh), .ack(ack_nh), .busy(busy_nh),
    .grant_id(grant_id_nh), .tx_start(tx_start_nh), .tx_din(tx_din_nh), .tx_done_tick(done_nh)
  );

  // Transmitter stand-ins: done pulse FRAME+1 edges after the start pulse is taken.
  always @(posedge clk) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_cnt <= 0; model_done <= 1'b0;
    end else begin
      model_done <= 1'b0;
      if (tx_start) begin
        m_busy <= 1'b1; m_cnt <= FRAME;
      end else if (m_busy) begin
        if (m_cnt == 0) begin model_done <= 1'b1; m_busy <= 1'b0; end
        else m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      m_busy_nh <= 1'b0; m_cnt_nh <= 0; done_nh <= 1'b0;
    end else begin
      done_nh <= 1'b0;
      if (tx_start_nh) begin
        m_busy_nh <= 1'b1; m_cnt_nh <= FRAME;
      end else if (m_busy_nh) begin
        if (m_cnt_nh == 0) begin done_nh <= 1'b1; m_busy_nh <= 1'b0; end
        else m_cnt_nh <= m_cnt_nh - 1;
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (ack[i] === 1'b1) ack_cnt[i] <= ack_cnt[i] + 1;
  end

  task automatic get_byte(input bit nh, output logic [7:0] d, output logic [3:0] a,
                          output logic [1:0] g, output logic bz, output int cyc, output bit ok);
    ok = 1'b0; cyc = 0; d = 'x; a = 'x; g = 'x; bz = 'x;
    while (!ok && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if ((nh ? tx_start_nh : tx_start) === 1'b1) begin
        ok = 1'b1;
        d  = nh ? tx_din_nh : tx_din;
        a  = nh ? ack_nh : ack;
        g  = nh ? grant_id_nh : grant_id;
        bz = nh ? busy_nh : busy;
      end
    end
  endtask

  task automatic wait_done(input bit nh, output bit ok);
    int cyc;
    ok = 1'b0; cyc = 0;
    while (!ok && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if ((nh ? done_nh : done_in) === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_start !== 1'b0 || tx_din !== 8'h00 || ack !== 4'h0 || busy !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: got start=%b din=%h ack=%b busy=%b gid=%0d, want 0 00 0000 0 0",
               tx_start, tx_din, ack, busy, grant_id);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [7:0] d; logic [3:0] a; logic [1:0] g; logic bz; int cyc; bit ok; exp_t e; int a0;
    a0 = ack_cnt[0];
    din[7:0] = 8'h55; req[0] = 1'b1;
    exp_q.push_back('{8'hA0, 4'b0000, 2'd0});
    exp_q.push_back('{8'h55, 4'b0001, 2'd0});
    for (int n = 0; n < 2; n++) begin
      get_byte(1'b0, d, a, g, bz, cyc, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || d !== e.data || a !== e.ack || g !== e.gid || bz !== 1'b1 || cyc != 1) begin
        errors++;
        $display("FAIL single_byte%0d: got ok=%0d data=%h ack=%b gid=%0d busy=%b lat=%0d, want data=%h ack=%b gid=%0d busy=1 lat=1",
                 n, ok, d, a, g, bz, cyc, e.data, e.ack, e.gid);
      end
      if (ok) req = req & ~a;
      wait_done(1'b0, ok);
      @(negedge clk);
      checks++;
      if (!ok || busy !== (n == 0)) begin
        errors++;
        $display("FAIL single_busy_after_done%0d: got done_seen=%0d busy=%b, want done_seen=1 busy=%b", n, ok, busy, n == 0);
      end
      if (n == 0) begin
        checks++;
        if (tx_start !== 1'b1 || tx_din !== 8'h55) begin
          errors++;
          $display("FAIL single_hdr_to_data: got start=%b din=%h, want start=1 din=55", tx_start, tx_din);
        end
        exp_q.pop_front();
        checks++;
        if (ack !== 4'b0001) begin
          errors++;
          $display("FAIL single_data_ack: got ack=%b, want 0001", ack);
        end
        req = req & ~ack;
        wait_done(1'b0, ok);
        @(negedge clk);
        checks++;
        if (!ok || busy !== 1'b0) begin
          errors++;
          $display("FAIL single_busy_drop: got done_seen=%0d busy=%b, want done_seen=1 busy=0", ok, busy);
        end
        n = 2;
      end
    end
    checks++;
    if (ack_cnt[0] - a0 != 1) begin
      errors++;
      $display("FAIL single_ack_count: got %0d acks, want 1", ack_cnt[0] - a0);
    end
  endtask

  task automatic test_same_source;
    logic [7:0] d; logic [3:0] a; logic [1:0] g; logic bz; int cyc; bit ok; exp_t e; int extra;
    @(negedge clk);
    din[7:0] = 8'h66; req[0] = 1'b1;
    exp_q.push_back('{8'h66, 4'b0001, 2'd0});
    get_byte(1'b0, d, a, g, bz, cyc, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || d !== e.data || a !== e.ack || g !== e.gid || cyc != 1) begin
      errors++;
      $display("FAIL same_source_byte: got ok=%0d data=%h ack=%b gid=%0d lat=%0d, want data=%h ack=%b gid=%0d lat=1",
               ok, d, a, g, cyc, e.data, e.ack, e.gid);
    end
    if (ok) req = req & ~a;
    wait_done(1'b0, ok);
    extra = 0;
    repeat (FRAME + 4) begin
      @(negedge clk);
      if (tx_start === 1'b1) extra++;
    end
    checks++;
    if (!ok || extra != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL same_source_no_extra: got done_seen=%0d extra_starts=%0d busy=%b, want 1 0 0", ok, extra, busy);
    end
  endtask

  task automatic test_all_four;
    logic [7:0] d; logic [3:0] a; logic [1:0] g; logic bz; int cyc; bit ok; exp_t e; int base[4];
    for (int i = 0; i < 4; i++) base[i] = ack_cnt[i];
    din = 32'h44332211; req = 4'b1111;
    exp_q.push_back('{8'hA1, 4'b0000, 2'd1}); exp_q.push_back('{8'h22, 4'b0010, 2'd1});
    exp_q.push_back('{8'hA2, 4'b0000, 2'd2}); exp_q.push_back('{8'h33, 4'b0100, 2'd2});
    exp_q.push_back('{8'hA3, 4'b0000, 2'd3}); exp_q.push_back('{8'h44, 4'b1000, 2'd3});
    exp_q.push_back('{8'hA0, 4'b0000, 2'd0}); exp_q.push_back('{8'h11, 4'b0001, 2'd0});
    while (exp_q.size() > 0) begin
      get_byte(1'b0, d, a, g, bz, cyc, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || d !== e.data || a !== e.ack || g !== e.gid || bz !== 1'b1) begin
        errors++;
        $display("FAIL all_four_byte: got ok=%0d data=%h ack=%b gid=%0d busy=%b, want data=%h ack=%b gid=%0d busy=1",
                 ok, d, a, g, bz, e.data, e.ack, e.gid);
      end
      if (ok) req = req & ~a;
      wait_done(1'b0, ok);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ack_cnt[i] - base[i] != 1) begin
        errors++;
        $display("FAIL all_four_ack_count: requester %0d got %0d acks, want 1", i, ack_cnt[i] - base[i]);
      end
    end
  endtask

  task automatic test_withdraw;
    logic [7:0] d; logic [3:0] a; logic [1:0] g; logic bz; int cyc; bit ok; exp_t e; int a2; int extra;
    a2 = ack_cnt[2];
    din[23:16] = 8'h5A; req = 4'b0100;
    exp_q.push_back('{8'hA2, 4'b0000, 2'd2});
    get_byte(1'b0, d, a, g, bz, cyc, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || d !== e.data || a !== e.ack || g !== e.gid) begin
      errors++;
      $display("FAIL withdraw_hdr: got ok=%0d data=%h ack=%b gid=%0d, want data=%h ack=%b gid=%0d",
               ok, d, a, g, e.data, e.ack, e.gid);
    end
    req = 4'b0000;
    wait_done(1'b0, ok);
    extra = 0;
    repeat (FRAME + 4) begin
      @(negedge clk);
      if (tx_start === 1'b1) extra++;
    end
    checks++;
    if (!ok || extra != 0 || busy !== 1'b0 || ack_cnt[2] != a2) begin
      errors++;
      $display("FAIL withdraw_no_data: got done_seen=%0d extra_starts=%0d busy=%b acks=%0d, want 1 0 0 0",
               ok, extra, busy, ack_cnt[2] - a2);
    end
    din[23:16] = 8'h5B; req = 4'b0100;
    exp_q.push_back('{8'h5B, 4'b0100, 2'd2});
    get_byte(1'b0, d, a, g, bz, cyc, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || d !== e.data || a !== e.ack || g !== e.gid) begin
      errors++;
      $display("FAIL withdraw_resend: got ok=%0d data=%h ack=%b gid=%0d, want data=%h ack=%b gid=%0d",
               ok, d, a, g, e.data, e.ack, e.gid);
    end
    if (ok) req = req & ~a;
    wait_done(1'b0, ok);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [7:0] d; logic [3:0] a; logic [1:0] g; logic bz; int cyc; bit ok; exp_t e;
    din[15:8] = 8'h3C; req = 4'b0010;
    exp_q.push_back('{8'hA1, 4'b0000, 2'd1});
    exp_q.push_back('{8'h3C, 4'b0010, 2'd1});
    while (exp_q.size() > 0) begin
      get_byte(1'b0, d, a, g, bz, cyc, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || d !== e.data || a !== e.ack || g !== e.gid) begin
        errors++;
        $display("FAIL reset_mid_pre: got ok=%0d data=%h ack=%b gid=%0d, want data=%h ack=%b gid=%0d",
                 ok, d, a, g, e.data, e.ack, e.gid);
      end
      if (ok) req = req & ~a;
      if (exp_q.size() > 0) wait_done(1'b0, ok);
    end
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0 || tx_din !== 8'h00 || ack !== 4'h0 || busy !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_values: got start=%b din=%h ack=%b busy=%b gid=%0d, want 0 00 0000 0 0",
               tx_start, tx_din, ack, busy, grant_id);
    end
    reset_n = 1'b1;
    din[15:8] = 8'h3D; req = 4'b0010;
    exp_q.push_back('{8'hA1, 4'b0000, 2'd1});
    exp_q.push_back('{8'h3D, 4'b0010, 2'd1});
    while (exp_q.size() > 0) begin
      get_byte(1'b0, d, a, g, bz, cyc, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || d !== e.data || a !== e.ack || g !== e.gid) begin
        errors++;
        $display("FAIL reset_mid_post: got ok=%0d data=%h ack=%b gid=%0d, want data=%h ack=%b gid=%0d",
                 ok, d, a, g, e.data, e.ack, e.gid);
      end
      if (ok) req = req & ~a;
      wait_done(1'b0, ok);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_spurious_done;
    logic [7:0] d; logic [3:0] a; logic [1:0] g; logic bz; int cyc; bit ok; exp_t e; int bad;
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx_start !== 1'b0 || busy !== 1'b0 || ack !== 4'h0 || tx_din !== 8'h3D || grant_id !== 2'd1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL spurious_done_idle: got start=%b busy=%b ack=%b din=%h gid=%0d, want 0 0 0000 3d 1",
               tx_start, busy, ack, tx_din, grant_id);
    end
    din[15:8] = 8'h3E; req = 4'b0010;
    exp_q.push_back('{8'h3E, 4'b0010, 2'd1});
    get_byte(1'b0, d, a, g, bz, cyc, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || d !== e.data || a !== e.ack || g !== e.gid) begin
      errors++;
      $display("FAIL spurious_then_byte: got ok=%0d data=%h ack=%b gid=%0d, want data=%h ack=%b gid=%0d",
               ok, d, a, g, e.data, e.ack, e.gid);
    end
    if (ok) req = req & ~a;
    wait_done(1'b0, ok);
    @(negedge clk);
  endtask

  task automatic test_no_header;
    logic [7:0] d; logic [3:0] a; logic [1:0] g; logic bz; int cyc; bit ok; exp_t e; int extra;
    din_nh[31:24] = 8'h7E; req_nh = 4'b1000;
    exp_q.push_back('{8'h7E, 4'b1000, 2'd3});
    exp_q.push_back('{8'h7F, 4'b1000, 2'd3});
    while (exp_q.size() > 0) begin
      get_byte(1'b1, d, a, g, bz, cyc, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || d !== e.data || a !== e.ack || g !== e.gid || cyc > 2) begin
        errors++;
        $display("FAIL no_header_byte: got ok=%0d data=%h ack=%b gid=%0d lat=%0d, want data=%h ack=%b gid=%0d lat<=2",
                 ok, d, a, g, cyc, e.data, e.ack, e.gid);
      end
      if (ok) req_nh = req_nh & ~a;
      wait_done(1'b1, ok);
      if (exp_q.size() > 0) begin
        din_nh[31:24] = 8'h7F; req_nh = 4'b1000;
      end
    end
    extra = 0;
    repeat (FRAME + 4) begin
      @(negedge clk);
      if (tx_start_nh === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || busy_nh !== 1'b0) begin
      errors++;
      $display("FAIL no_header_quiet: got extra_starts=%0d busy=%b, want 0 0", extra, busy_nh);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_same_source;
    test_all_four;
    test_withdraw;
    test_reset_mid;
    test_spurious_done;
    test_no_header;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` transmitter between NREQ byte-stream requesters. It sits between client logic and the transmitter's `tx_start`/`tx_din`/`tx_done_tick` handshake. It grants one byte per arbitration round. When the granted source differs from the previous one, it optionally prefixes the byte with a source-ID header byte so the far end can demultiplex.

## Interface
- NREQ, 4, number of requesters (2..16)
- DBIT, 8, data width; must match `uart_tx` DBIT
- HDR_EN, 1, 1 = emit a header byte on source change; 0 = never
- HDR_BASE, 8'hA0, header value base; header = (HDR_BASE + id) truncated to DBIT
- IDW, derived: ceil(log2 NREQ), minimum 1

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- req  in  NREQ  per-requester byte-valid level; must stay high until ack
- din  in  NREQ*DBIT  per-requester data; requester i uses bits [i*DBIT +: DBIT]
- ack  out  NREQ  one-cycle pulse; byte from requester i has been handed to the transmitter
- busy  out  1  high from grant until the transaction completes
- grant_id  out  IDW  currently or last granted requester
- tx_start  out  1  one-cycle start pulse to `uart_tx`
- tx_din  out  DBIT  byte to `uart_tx`; valid while tx_start = 1 and held afterwards
- tx_done_tick  in  1  end-of-stop-bit pulse from `uart_tx`

## Operation
- All outputs are registered.
- Reset values: tx_start=0, tx_din=0, ack=0, busy=0, grant_id=0. Internal state: state=IDLE, ptr=0, hdr_valid=0 (no previous source).
- States: IDLE, WAIT_HDR, WAIT_DATA.
- IDLE, no req bit set: hold.
- IDLE, any req bit set:
  - Select the first set bit scanning ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - Set grant_id := id and busy := 1.
  - If HDR_EN=1 and (hdr_valid=0 or id != last_id): tx_start := 1, tx_din := HDR_BASE+id, then go to WAIT_HDR.
  - Otherwise: tx_start := 1, tx_din := din[id], ack[id] := 1, then go to WAIT_DATA.
- WAIT_HDR on tx_done_tick:
  - last_id := id and hdr_valid := 1.
  - If req[id]=1: tx_start := 1, tx_din := din[id], ack[id] := 1, then go to WAIT_DATA.
  - If req[id]=0 (requester withdrew): no data byte and no ack. Set busy := 0, ptr := id+1 mod NREQ, then go to IDLE.
- WAIT_DATA on tx_done_tick: busy := 0, ptr := id+1 mod NREQ, last_id := id, then go to IDLE.
- tx_start and ack are single-cycle pulses and are cleared on the following edge.
- tx_din holds its value until the next load.
- tx_done_tick is ignored in IDLE.
- req changes during WAIT_* do not affect the current grant, except the withdrawal check at the end of WAIT_HDR.
- din[id] is sampled only on the edge that asserts ack[id]. The requester may change din or drop req from the next cycle on.
- Fairness: a continuously requesting source waits at most NREQ-1 transactions.

## Timing
- Latency: req sampled high in IDLE at edge N gives tx_start=1 and busy=1 in cycle N+1.
- Header to data: tx_done_tick high at edge M gives a data tx_start in cycle M+1. `uart_tx` is back in idle by then.
- Completion: tx_done_tick at edge M gives busy=0 and IDLE in cycle M+1. The earliest next grant is edge M+1, with tx_start in cycle M+2.
- A header-free byte costs one transmitter frame plus 2 idle cycles. A headed byte costs two frames plus 3 cycles.
- Reset asserted in any state forces reset values on the next edge. No ack is issued for an interrupted byte.
- After reset, hdr_valid=0, so the next grant always emits a header when HDR_EN=1.
- `uart_tx` shares reset_n and is reset simultaneously.

## Test plan
- Single requester: after reset, req[0]=1 with din[0]=0x55, HDR_EN=1 -> tx_start carries 0xA0, then 0x55 one cycle after tx_done_tick. ack[0] pulses once, in the 0x55 tx_start cycle. busy drops one cycle after the second done tick.
- Same source again: req[0] with 0x66 -> a single tx_start with 0x66, no header, ack[0] in the same cycle.
- All four requesting after requester 0 was served, din = 0x11/0x22/0x33/0x44 -> grant order 1,2,3,0, each as header A1/A2/A3/A0 followed by its data byte. Exactly one ack per requester.
- Withdrawal: req[2] drops during WAIT_HDR -> header 0xA2 sent, no data, ack[2] never pulses, ptr=3. A following req[2] sends its data with no header.
- Reset during WAIT_DATA -> next cycle all outputs are at reset values. The next req[1] yields header 0xA1 before its data.
- Spurious tx_done_tick in IDLE with no req -> no output change. With HDR_EN=0 and req[3]=0x7E -> only 0x7E is sent.
